// File: rtl/popcount_mask_gen_if.sv
// popcount_mask_gen_if: start/count request and done/mask/error response
// bundle for popcount_mask_gen. The requester uses the master modport and
// the mask generator uses the slave modport.
interface popcount_mask_gen_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;  // level request, held until done is seen
    logic [CW-1:0]    count;  // requested number of set bits
    logic             done;   // high only while the result is presented
    logic [WIDTH-1:0] mask;   // generated mask, valid while done = 1
    logic             error;  // captured count exceeded WIDTH

    modport master (
        output start,
        output count,
        input  done,
        input  mask,
        input  error
    );

    modport slave (
        input  start,
        input  count,
        output done,
        output mask,
        output error
    );
endinterface

// File: rtl/popcount_mask_gen.sv
// popcount_mask_gen: sequential inverse of the bit counter. Converts a
// population count into a WIDTH-bit mask with exactly that many bits set,
// adding one bit per clock. Uses a level-held start / done handshake.
//
// Optional build macro: POPMASK_MSB_FIRST_EN
//   defined   -> mask fills from the MSB side (count=3 -> 8'b1110_0000)
//   undefined -> mask fills from the LSB side (count=3 -> 8'b0000_0111)
// Latency, handshake and error behaviour are identical in both builds.
module popcount_mask_gen #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    popcount_mask_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // WIDTH expressed at count width so the overflow compare is unsigned
    // and CW bits wide.
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [CW-1:0]    remaining_q;
    logic             ovf_q;
    logic             done_q;
    logic             error_q;

    // Next mask value for one fill step: shift in a single 1 bit.
    always_comb begin
        mask_d = mask_q;
`ifdef POPMASK_MSB_FIRST_EN
        mask_d = {1'b1, mask_q[WIDTH-1:1]};
`else
        mask_d = {mask_q[WIDTH-2:0], 1'b1};
`endif
    end

    // Control FSM with registered done/error; mask and counter update here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            remaining_q <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    if (bus.start) begin
                        remaining_q <= bus.count;
                        ovf_q       <= (bus.count > WIDTH_C);
                        mask_q      <= '0;
                        state_q     <= S_BUILD;
                    end
                end

                S_BUILD: begin
                    if (ovf_q) begin
                        mask_q  <= '1;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else if (remaining_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b0;
                    end else begin
                        // Decrement is gated by remaining != 0, so it never wraps.
                        mask_q      <= mask_d;
                        remaining_q <= remaining_q - CW'(1);
                    end
                end

                S_DONE: begin
                    if (!bus.start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done  = done_q;
    assign bus.mask  = mask_q;
    assign bus.error = error_q;

endmodule
